irq_combiner: RTL

Parametrised interrupt combiner; the sequential successor of the plain 4-input OR used to merge interrupt lines in the SoC. Collects NUM_SRC peripheral interrupt lines and captures rising edges into sticky pending bits. Applies a per-source mask and drives one registered CPU interrupt plus a priority-encoded source ID. Software uses a small register interface on the SoC bus.

---
 rtl/irq_combiner_pkg.sv | 16 +
 rtl/irq_combiner_if.sv | 25 ++
 rtl/irq_prio_enc.sv | 23 ++
 rtl/irq_combiner.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/irq_combiner_pkg.sv
// Shared constants for the interrupt combiner: register addresses and reset values.
package irq_combiner_pkg;

    // Largest supported source count; used to size reset-value constants.
    localparam int MAX_SRC = 32;

    // Register map on the software bus.
    localparam logic [1:0] ADDR_PENDING = 2'd0;
    localparam logic [1:0] ADDR_MASK    = 2'd1;
    localparam logic [1:0] ADDR_ACTIVE  = 2'd2;
    localparam logic [1:0] ADDR_ID      = 2'd3;

    // All sources are disabled out of reset.
    localparam logic [MAX_SRC-1:0] MASK_RST = '0;

endpackage

// File: rtl/irq_combiner_if.sv
// Software register bus of the interrupt combiner.
// The master side drives the write strobe, address and write data.
// The slave side returns read data, combinationally from the address.
interface irq_combiner_if #(
    parameter int NUM_SRC = 4
);
    logic               we;
    logic [1:0]         addr;
    logic [NUM_SRC-1:0] wdata;
    logic [NUM_SRC-1:0] rdata;

    modport master (
        output we,
        output addr,
        output wdata,
        input  rdata
    );

    modport slave (
        input  we,
        input  addr,
        input  wdata,
        output rdata
    );
endinterface

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder, purely combinational.
// id is 0 when no request is set; valid flags a non-empty request vector.
module irq_prio_enc #(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_SRC-1:0] req,
    output logic [ID_W-1:0]    id,
    output logic               valid
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        id    = '0;
        valid = |req;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                id = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_combiner.sv
// Interrupt combiner: captures rising edges of NUM_SRC lines into sticky
// pending bits, masks them, and drives a registered CPU interrupt with the
// index of the lowest-numbered active source.
// Optional build macro IRQ_SYNC_EN: adds a 2-flop synchroniser per source
// line for sources that are asynchronous to clk (2 extra cycles of latency).
module irq_combiner
    import irq_combiner_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_SRC-1:0]  src_in,
    irq_combiner_if.slave       bus,
    output logic                irq_out,
    output logic [ID_W-1:0]     irq_id,
    output logic                irq_valid
);

    logic [NUM_SRC-1:0] s;
    logic [NUM_SRC-1:0] s_d;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] clr;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] pending_next;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] active;
    logic [NUM_SRC-1:0] id_word;
    logic [ID_W-1:0]    enc_id;
    logic               enc_valid;

`ifdef IRQ_SYNC_EN
    logic [NUM_SRC-1:0] sync_a;
    logic [NUM_SRC-1:0] sync_b;

    // Two-flop synchroniser bringing each source line into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= src_in;
            sync_b <= sync_a;
        end
    end

    assign s = sync_b;
`else
    assign s = src_in;
`endif

    // Previous-cycle copy of the source stage for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_d <= '0;
        end else begin
            s_d <= s;
        end
    end

    // One rise pulse per low-to-high transition of each line.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_edge
            assign rise[gi] = s[gi] & ~s_d[gi];
        end
    endgenerate

    // Write-1-to-clear mask for PENDING; a new edge on the same cycle wins.
    always_comb begin
        clr = '0;
        if (bus.we && (bus.addr == ADDR_PENDING)) begin
            clr = bus.wdata;
        end
        pending_next = (pending & ~clr) | rise;
    end

    // Sticky pending bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    // Per-source enable register, written directly by software.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask <= MASK_RST[NUM_SRC-1:0];
        end else if (bus.we && (bus.addr == ADDR_MASK)) begin
            mask <= bus.wdata;
        end
    end

    // Masked pending bits are kept in pending; only the enabled ones are active.
    assign active = pending & mask;

    irq_prio_enc #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_prio_enc (
        .req   (active),
        .id    (enc_id),
        .valid (enc_valid)
    );

    // Registered CPU-facing outputs, refreshed every cycle from active.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_out   <= 1'b0;
            irq_id    <= '0;
            irq_valid <= 1'b0;
        end else begin
            irq_out   <= enc_valid;
            irq_id    <= enc_id;
            irq_valid <= enc_valid;
        end
    end

    // ID register layout: low bits carry irq_id, the top bit carries irq_valid.
    always_comb begin
        id_word              = '0;
        id_word[ID_W-1:0]    = irq_id;
        id_word[NUM_SRC-1]   = irq_valid;
    end

    // Read mux, combinational from the address.
    always_comb begin
        bus.rdata = '0;
        case (bus.addr)
            ADDR_PENDING: bus.rdata = pending;
            ADDR_MASK:    bus.rdata = mask;
            ADDR_ACTIVE:  bus.rdata = active;
            ADDR_ID:      bus.rdata = id_word;
            default:      bus.rdata = '0;
        endcase
    end

endmodule
